// File: rtl/sti_pkg.sv
// Shared definitions for the STI command loader.
//  - FSM state encoding (3 bits)
//  - command-word field offsets and packed view
//  - length codes and len_bits(): serial bit count for a length code
package sti_pkg;

  localparam int unsigned WORD_W   = 21;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LEN_W    = 2;
  localparam int unsigned BITCNT_W = 6;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned LEN_LSB  = 16;
  localparam int unsigned FILL_BIT = 18;
  localparam int unsigned MSB_BIT  = 19;
  localparam int unsigned LOW_BIT  = 20;

  localparam logic [LEN_W-1:0] LEN_8  = 2'b00;
  localparam logic [LEN_W-1:0] LEN_16 = 2'b01;
  localparam logic [LEN_W-1:0] LEN_24 = 2'b10;
  localparam logic [LEN_W-1:0] LEN_32 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_LOAD       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_NEXT       = 3'd5,
    ST_END        = 3'd6
  } state_e;

  typedef struct packed {
    logic              low;
    logic              msb;
    logic              fill;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

  // Serial bit count for a length code: 8*(len+1)
  function automatic logic [BITCNT_W-1:0] len_bits(input logic [LEN_W-1:0] len);
    logic [BITCNT_W-1:0] b;
    b = 6'd32;
    case (len)
      LEN_8:  b = 6'd8;
      LEN_16: b = 6'd16;
      LEN_24: b = 6'd24;
      LEN_32: b = 6'd32;
    endcase
    return b;
  endfunction

  // Split a raw ROM word into its fields
  function automatic cmd_word_t cmd_word_unpack(input logic [WORD_W-1:0] w);
    cmd_word_t u;
    u.data   = w[DATA_LSB +: DATA_W];
    u.length = w[LEN_LSB +: LEN_W];
    u.fill   = w[FILL_BIT];
    u.msb    = w[MSB_BIT];
    u.low    = w[LOW_BIT];
    return u;
  endfunction

endpackage

// File: rtl/sti_cmd_loader.sv
// sti_cmd_loader: fetches command words from a synchronous ROM and feeds the
// STI serializer one word at a time, pacing on so_valid.
//  clk, reset(async, active-low), start, cmd_count  : control inputs
//  cmd_addr / cmd_rdata                             : ROM port (1-cycle read latency)
//  so_valid                                         : serializer busy-shifting flag
//  load, pi_*                                       : parallel-load interface
//  busy, done, err_len, err_timeout                 : status (errors sticky per run)
module sti_cmd_loader
  import sti_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   cmd_count,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_rdata,
  input  logic              so_valid,
  output logic              load,
  output logic [DATA_W-1:0] pi_data,
  output logic [LEN_W-1:0]  pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    word_idx_q, word_idx_d;
  logic [CNT_W-1:0]    word_idx_inc;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                load_q, load_d;
  cmd_word_t           pi_q, pi_d;
  logic                pi_end_q, pi_end_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
  logic                err_tmo_q, err_tmo_d;
  logic                tmo_hit;
  cmd_word_t           word;

  assign word         = cmd_word_unpack(cmd_rdata);
  assign word_idx_inc = word_idx_q + CNT_W'(1);
  assign tmo_hit      = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = (cmd_count == '0) ? ST_END : ST_FETCH;
      ST_FETCH:      state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (so_valid)     state_d = ST_WAIT_DONE;
        else if (tmo_hit) state_d = ST_NEXT;
      end
      ST_WAIT_DONE:  if (!so_valid) state_d = ST_NEXT;
      ST_NEXT:       state_d = (word_idx_inc == cnt_q) ? ST_END : ST_FETCH;
      ST_END:        state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    cmd_addr_d = cmd_addr_q;
    tmo_cnt_d  = tmo_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pi_d       = pi_q;
    pi_end_d   = pi_end_q;
    err_len_d  = err_len_q;
    err_tmo_d  = err_tmo_q;
    load_d     = 1'b0;
    done_d     = (state_d == ST_END);
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = cmd_count;
          word_idx_d = '0;
          cmd_addr_d = '0;
          bit_cnt_d  = '0;
          pi_end_d   = 1'b0;
          err_len_d  = 1'b0;
          err_tmo_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        pi_d      = word;
        load_d    = 1'b1;
        tmo_cnt_d = '0;
      end
      ST_WAIT_START: begin
        if (so_valid)     bit_cnt_d = BITCNT_W'(1);
        else if (tmo_hit) err_tmo_d = 1'b1;
        else              tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
      ST_WAIT_DONE: begin
        // Bit counter saturates so a runaway so_valid cannot wrap into a match
        if (so_valid) begin
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
        end else if (bit_cnt_q != len_bits(pi_q.length)) begin
          err_len_d = 1'b1;
        end
      end
      ST_NEXT: begin
        word_idx_d = word_idx_inc;
        if (word_idx_inc != cnt_q) cmd_addr_d = cmd_addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
    if (state_d == ST_END) pi_end_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      word_idx_q <= '0;
      cmd_addr_q <= '0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      load_q     <= 1'b0;
      pi_q       <= '0;
      pi_end_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      cmd_addr_q <= cmd_addr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      load_q     <= load_d;
      pi_q       <= pi_d;
      pi_end_q   <= pi_end_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign cmd_addr    = cmd_addr_q;
  assign load        = load_q;
  assign pi_data     = pi_q.data;
  assign pi_length   = pi_q.length;
  assign pi_fill     = pi_q.fill;
  assign pi_msb      = pi_q.msb;
  assign pi_low      = pi_q.low;
  assign pi_end      = pi_end_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_sti_cmd_loader.sv
// Directed bench for sti_cmd_loader with a synchronous ROM and a
// serializer model that drives so_valid for a chosen number of cycles.
module tb_sti_cmd_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  cmd_count;
  logic [7:0]  cmd_addr;
  logic [20:0] cmd_rdata;
  logic        so_valid;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end, busy, done, err_len, err_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int load_cnt = 0;

  logic [20:0] rom [256];

  sti_cmd_loader #(.ADDR_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_count(cmd_count),
    .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata), .so_valid(so_valid),
    .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .busy(busy),
    .done(done), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous command ROM
  always @(posedge clk) cmd_rdata <= rom[cmd_addr];

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (load) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic low, input logic msb, input logic fill,
                                     input logic [1:0] len, input logic [15:0] data);
    return {low, msb, fill, len, data};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start; returns the edge index that samples it
  task automatic do_start(input int count, output int start_edge);
    cmd_count  = 9'(count);
    start      = 1'b1;
    start_edge = cyc + 1;
    tick(1);
    start      = 1'b0;
  endtask

  // Wait (bounded) for load; returns the edge after which load is high
  task automatic wait_load(input string tag, output int load_edge, output bit ok);
    ok = 1'b0;
    load_edge = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load) begin
        ok = 1'b1;
        load_edge = cyc;
        break;
      end
    end
    if (!ok) check({tag, "_load_seen"}, 64'd0, 64'd1);
  endtask

  // Serializer model: called at the negedge of the load cycle
  task automatic serve(input int nbits, output int fall_edge);
    @(posedge clk); #1;
    so_valid = 1'b1;
    tick(nbits);
    so_valid  = 1'b0;
    fall_edge = cyc + 1;
  endtask

  // Let the run finish and check completion status
  task automatic tail(input string tag, input int d0, input logic exp_len, input logic exp_tmo);
    repeat (8) @(negedge clk);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_pi_end"},    64'(pi_end), 64'd1);
    check({tag, "_idle"},      64'(busy), 64'd0);
    check({tag, "_err_len"},   64'(err_len), 64'(exp_len));
    check({tag, "_err_tmo"},   64'(err_timeout), 64'(exp_tmo));
  endtask

  initial begin
    int se, le, fe, pfe, d0, l0, ee;
    bit ok;
    reset = 1'b0; start = 1'b0; cmd_count = '0; so_valid = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    tick(3);
    check("reset_outputs",
          64'({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy,
               done, err_len, err_timeout, cmd_addr}), 64'd0);
    reset = 1'b1;
    tick(2);

    // 1) single 8-bit word
    rom[0] = mk(1'b1, 1'b0, 1'b0, 2'b00, 16'hA55A);
    d0 = done_cnt;
    do_start(1, se);
    wait_load("t1", le, ok);
    if (ok) begin
      check("t1_latency", 64'(le - se), 64'd2);
      check("t1_pi_data", 64'(pi_data), 64'hA55A);
      check("t1_pi_len",  64'(pi_length), 64'd0);
      check("t1_modes",   64'({pi_low, pi_msb, pi_fill}), 64'b100);
      check("t1_busy",    64'(busy), 64'd1);
      serve(8, fe);
    end
    tail("t1", d0, 1'b0, 1'b0);

    // 2) four words, all lengths, fall-to-load gap
    for (int i = 0; i < 4; i++)
      rom[i] = mk(1'(i & 1), 1'(i >> 1), 1'b1, 2'(i), 16'h1000 + 16'(i));
    d0 = done_cnt;
    pfe = 0;
    do_start(4, se);
    for (int i = 0; i < 4; i++) begin
      wait_load($sformatf("t2_w%0d", i), le, ok);
      if (!ok) break;
      if (i > 0) check($sformatf("t2_gap%0d", i), 64'(le - pfe), 64'd3);
      check($sformatf("t2_addr%0d", i), 64'(cmd_addr), 64'(i));
      check($sformatf("t2_word%0d", i),
            64'({pi_low, pi_msb, pi_fill, pi_length, pi_data}), 64'(rom[i]));
      serve(8 * (i + 1), pfe);
    end
    tail("t2", d0, 1'b0, 1'b0);

    // 3) length mismatch: 16-bit word, 15 so_valid cycles
    rom[0] = mk(1'b0, 1'b1, 1'b0, 2'b01, 16'hBEEF);
    d0 = done_cnt;
    do_start(1, se);
    wait_load("t3", le, ok);
    if (ok) serve(15, fe);
    tail("t3", d0, 1'b1, 1'b0);
    tick(3);
    check("t3_err_len_sticky", 64'(err_len), 64'd1);

    // 4) timeout on word 0, word 1 still fetched and served
    rom[0] = mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0101);
    rom[1] = mk(1'b0, 1'b0, 1'b1, 2'b00, 16'h0202);
    d0 = done_cnt;
    do_start(2, se);
    wait_load("t4_w0", l0, ok);
    if (ok) begin
      check("t4_err_clr_on_start", 64'(err_len), 64'd0);
      ee = -1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (err_timeout) begin ee = cyc; break; end
      end
      check("t4_tmo_cycle", 64'(ee - l0), 64'd64);
      wait_load("t4_w1", le, ok);
      if (ok) begin
        check("t4_next_gap", 64'(le - ee), 64'd3);
        check("t4_addr1",    64'(cmd_addr), 64'd1);
        check("t4_data1",    64'(pi_data), 64'h0202);
        serve(8, fe);
      end
    end
    tail("t4", d0, 1'b0, 1'b1);

    // 5) zero-length run; start held into END must be ignored
    d0 = done_cnt;
    l0 = load_cnt;
    cmd_count = '0;
    start = 1'b1;
    se = cyc + 1;
    @(negedge clk);
    check("t5_done_at_start", 64'({done, pi_end, busy}), 64'b111);
    tick(1);
    @(negedge clk);
    check("t5_end_ignores_start", 64'({done, busy}), 64'd0);
    start = 1'b0;
    tick(4);
    check("t5_done_once", 64'(done_cnt - d0), 64'd1);
    check("t5_no_load",   64'(load_cnt - l0), 64'd0);
    check("t5_pi_end",    64'(pi_end), 64'd1);

    // 6) async reset in WAIT_DONE of the second word, then restart
    rom[0] = mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h3C3C);
    rom[1] = mk(1'b1, 1'b1, 1'b1, 2'b01, 16'hC3C3);
    rom[2] = mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0003);
    do_start(3, se);
    wait_load("t6_w0", le, ok);
    if (ok) serve(8, fe);
    wait_load("t6_w1", le, ok);
    if (ok) begin
      @(posedge clk); #1;
      so_valid = 1'b1;
      tick(3);
      check("t6_pre_reset_busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_async_reset",
            64'({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy,
                 done, err_len, err_timeout, cmd_addr}), 64'd0);
      so_valid = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
    end
    d0 = done_cnt;
    do_start(1, se);
    wait_load("t6_restart", le, ok);
    if (ok) begin
      check("t6_restart_addr", 64'(cmd_addr), 64'd0);
      check("t6_restart_data", 64'(pi_data), 64'h3C3C);
      serve(8, fe);
    end
    tail("t6", d0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
